song_player: RTL and testbench



---
 rtl/song_player_pkg.sv | 46 ++++
 rtl/song_player_rom.sv | 26 ++
 rtl/song_player.sv | 160 ++++++++++++++++
 tb/tb_song_player.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/song_player_pkg.sv
// Shared constants for the autoplay melody sequencer.
// Note codes, LED patterns, song length and FSM state encoding.
package song_player_pkg;

    localparam logic [3:0] NOTE_NONE = 4'h0;
    localparam logic [3:0] NOTE_C4   = 4'h1;
    localparam logic [3:0] NOTE_D    = 4'h2;
    localparam logic [3:0] NOTE_E    = 4'h3;
    localparam logic [3:0] NOTE_F    = 4'h4;
    localparam logic [3:0] NOTE_G    = 4'h5;

    localparam logic [7:0] LED_NONE  = 8'h00;
    localparam logic [7:0] LED_C4    = 8'h01;
    localparam logic [7:0] LED_D     = 8'h02;
    localparam logic [7:0] LED_E     = 8'h04;
    localparam logic [7:0] LED_F     = 8'h08;
    localparam logic [7:0] LED_G     = 8'h10;

    localparam int         SONG_LEN  = 15;
    localparam logic [3:0] LAST_IDX  = 4'(SONG_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    typedef struct packed {
        logic [3:0] note;
        logic [2:0] dur;
    } rom_word_t;

    function automatic logic [7:0] led_of(input logic [3:0] n);
        logic [7:0] p;
        case (n)
            NOTE_C4: p = LED_C4;
            NOTE_D:  p = LED_D;
            NOTE_E:  p = LED_E;
            NOTE_F:  p = LED_F;
            NOTE_G:  p = LED_G;
            default: p = LED_NONE;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/song_player_rom.sv
// Melody table: index -> note code and duration in half-beats.
// Indices past the end of the phrase read as a one half-beat rest.
module song_rom
    import song_player_pkg::*;
(
    input  logic [3:0] i_idx,
    output rom_word_t  o_word
);

    // Ode to Joy phrase lookup
    always_comb begin
        o_word = '{note: NOTE_NONE, dur: 3'd1};
        case (i_idx)
            4'd0, 4'd1, 4'd6, 4'd11: o_word = '{note: NOTE_E,  dur: 3'd2};
            4'd2, 4'd5:              o_word = '{note: NOTE_F,  dur: 3'd2};
            4'd3, 4'd4:              o_word = '{note: NOTE_G,  dur: 3'd2};
            4'd7, 4'd10:             o_word = '{note: NOTE_D,  dur: 3'd2};
            4'd8, 4'd9:              o_word = '{note: NOTE_C4, dur: 3'd2};
            4'd12:                   o_word = '{note: NOTE_E,  dur: 3'd3};
            4'd13:                   o_word = '{note: NOTE_D,  dur: 3'd1};
            4'd14:                   o_word = '{note: NOTE_D,  dur: 3'd4};
            default:                 o_word = '{note: NOTE_NONE, dur: 3'd1};
        endcase
    end

endmodule

// File: rtl/song_player.sv
// Autoplay sequencer driving the note bus and LEDs from the melody ROM.
// Each note sounds L-GAP ticks followed by GAP ticks of silence.
module song_player
    import song_player_pkg::*;
#(
    parameter int HALF_TICKS = 4,
    parameter int GAP_TICKS  = 1,
    parameter int CNT_W      = 8
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       loop,
    output logic [3:0] note,
    output logic [7:0] Led,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] PLAY_SUB = CNT_W'(GAP_TICKS + 1);
    localparam logic [CNT_W-1:0] GAP_END  = CNT_W'(GAP_TICKS - 1);

    state_t           r_state;
    logic [3:0]       r_idx;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_len;
    logic [3:0]       r_note;
    logic [7:0]       r_led;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [3:0]       w_idx_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_len_nxt;
    logic             w_fin;
    logic [3:0]       w_note_nxt;
    logic [7:0]       w_led_nxt;
    logic             w_busy_nxt;
    rom_word_t        w_rom;

    // ROM looks ahead at the next index so outputs register with the state
    song_rom u_rom (
        .i_idx  (w_idx_nxt),
        .o_word (w_rom)
    );

    assign w_len_nxt = CNT_W'(w_rom.dur) * CNT_W'(HALF_TICKS);

    // State, counters and registered outputs
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_idx   <= 4'd0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_note  <= NOTE_NONE;
            r_led   <= LED_NONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_note  <= w_note_nxt;
            r_led   <= w_led_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_fin;
        end
    end

    // Next-state: stop overrides everything, timing advances only on tick
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_fin       = 1'b0;
        if (stop) begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 4'd0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        w_state_nxt = ST_PLAY;
                        w_idx_nxt   = 4'd0;
                        w_cnt_nxt   = '0;
                    end
                end
                ST_PLAY: begin
                    if (tick) begin
                        if (r_cnt == r_len - PLAY_SUB) begin
                            w_state_nxt = ST_GAP;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + ONE;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (r_cnt == GAP_END) begin
                            w_cnt_nxt = '0;
                            if (r_idx < LAST_IDX) begin
                                w_state_nxt = ST_PLAY;
                                w_idx_nxt   = r_idx + 4'd1;
                            end else if (loop) begin
                                w_state_nxt = ST_PLAY;
                                w_idx_nxt   = 4'd0;
                            end else begin
                                w_state_nxt = ST_IDLE;
                                w_idx_nxt   = 4'd0;
                                w_fin       = 1'b1;
                            end
                        end else begin
                            w_cnt_nxt = r_cnt + ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = 4'd0;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    // Output values for the state being entered; gap keeps the LEDs lit
    always_comb begin
        w_note_nxt = NOTE_NONE;
        w_led_nxt  = LED_NONE;
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        case (w_state_nxt)
            ST_PLAY: begin
                w_note_nxt = w_rom.note;
                w_led_nxt  = led_of(w_rom.note);
            end
            ST_GAP: begin
                w_note_nxt = NOTE_NONE;
                w_led_nxt  = r_led;
            end
            default: begin
                w_note_nxt = NOTE_NONE;
                w_led_nxt  = LED_NONE;
            end
        endcase
    end

    assign note = r_note;
    assign Led  = r_led;
    assign busy = r_busy;
    assign done = r_done;

endmodule

// File: tb/tb_song_player.sv
// Self-checking bench for song_player against a tick-timeline model.
// The model tracks ticks elapsed in the phrase and derives notes from it.
module tb_song_player;
    import song_player_pkg::*;

    localparam int HT    = 4;
    localparam int GT    = 1;
    localparam int TOTAL = 32 * HT;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic       tick, start, stop, loop;
    logic [3:0] note;
    logic [7:0] Led;
    logic       busy, done;

    int checks = 0;
    int errors = 0;

    logic [3:0] mel [15];
    int         dur [15];

    logic m_active;
    int   m_t;
    logic m_done;

    song_player #(.HALF_TICKS(HT), .GAP_TICKS(GT), .CNT_W(8)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .tick(tick), .start(start),
        .stop(stop), .loop(loop), .note(note), .Led(Led),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    initial begin
        mel = '{NOTE_E, NOTE_E, NOTE_F, NOTE_G, NOTE_G, NOTE_F, NOTE_E,
                NOTE_D, NOTE_C4, NOTE_C4, NOTE_D, NOTE_E, NOTE_E,
                NOTE_D, NOTE_D};
        dur = '{2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3, 1, 4};
    end

    // Model: ticks elapsed since the phrase began
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            m_active <= 1'b0; m_t <= 0; m_done <= 1'b0;
        end else if (stop) begin
            m_active <= 1'b0; m_t <= 0; m_done <= 1'b0;
        end else if (!m_active) begin
            m_done <= 1'b0;
            if (start) begin m_active <= 1'b1; m_t <= 0; end
        end else begin
            m_done <= 1'b0;
            if (tick) begin
                if (m_t + 1 == TOTAL) begin
                    if (loop) m_t <= 0;
                    else begin m_active <= 1'b0; m_t <= 0; m_done <= 1'b1; end
                end else m_t <= m_t + 1;
            end
        end
    end

    function automatic logic [3:0] exp_note(input int t);
        int s = 0;
        for (int k = 0; k < 15; k++) begin
            int len = dur[k] * HT;
            if (t < s + len) return (t - s < len - GT) ? mel[k] : NOTE_NONE;
            s += len;
        end
        return NOTE_NONE;
    endfunction

    function automatic logic [7:0] exp_led(input int t);
        int s = 0;
        for (int k = 0; k < 15; k++) begin
            s += dur[k] * HT;
            if (t < s) begin
                case (mel[k])
                    NOTE_C4: return LED_C4;
                    NOTE_D:  return LED_D;
                    NOTE_E:  return LED_E;
                    NOTE_F:  return LED_F;
                    default: return LED_G;
                endcase
            end
        end
        return 8'h00;
    endfunction

    function automatic logic [13:0] expv();
        if (!m_active) return {NOTE_NONE, 8'h00, 1'b0, m_done};
        return {exp_note(m_t), exp_led(m_t), 1'b1, m_done};
    endfunction

    function automatic logic [13:0] obs();
        return {note, Led, busy, done};
    endfunction

    task automatic test_reset();
        RESET_N = 1'b0; tick = 0; start = 0; stop = 0; loop = 0;
        repeat (3) @(negedge CLK);
        checks++;
        if (obs() !== 14'h0)
            $display("FAIL reset_state got %h exp %h", obs(), 14'h0);
        if (obs() !== 14'h0) errors++;
        RESET_N = 1'b1;
        tick = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int j = 1; j <= 43; j++) begin
            @(negedge CLK);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL reset_run j=%0d got %h exp %h", j, obs(), expv());
            end
        end
        checks++;
        if (note !== NOTE_F) begin
            errors++;
            $display("FAIL reset_idx5 got %h exp %h", note, NOTE_F);
        end
        #2 RESET_N = 1'b0;
        #1;
        checks++;
        if (obs() !== 14'h0) begin
            errors++;
            $display("FAIL reset_async got %h exp %h", obs(), 14'h0);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        repeat (5) begin
            @(negedge CLK);
            checks++;
            if (obs() !== 14'h0) begin
                errors++;
                $display("FAIL reset_idle got %h exp %h", obs(), 14'h0);
            end
        end
    endtask

    task automatic test_play_once(input bit poke, input string nm);
        int done_at = -1;
        tick = 1'b1; loop = 1'b0; stop = 1'b0;
        start = 1'b1;
        @(negedge CLK);
        for (int j = 1; j <= 135; j++) begin
            start = poke && (j >= 24) && (j <= 27);
            @(negedge CLK);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL %s j=%0d got %h exp %h", nm, j, obs(), expv());
            end
            if (j == 7 || j == 8) begin
                checks++;
                if (note !== ((j == 7) ? NOTE_NONE : NOTE_E)) begin
                    errors++;
                    $display("FAIL %s_ee_gap j=%0d got %h", nm, j, note);
                end
            end
            if (done === 1'b1 && done_at < 0) done_at = j;
        end
        start = 1'b0;
        checks++;
        if (done_at != 128 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done got %0d busy %b exp 128 busy 0", nm, done_at, busy);
        end
    endtask

    task automatic test_slow_tick();
        int e_run = 0;
        int g_run = 0;
        int phase = 0;
        tick = 1'b0; loop = 1'b0;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        if (note === NOTE_E) e_run++;
        for (int j = 1; j <= 200; j++) begin
            tick = (j % 10 == 0);
            @(negedge CLK);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL slow_tick j=%0d got %h exp %h", j, obs(), expv());
            end
            if (phase == 0 && note === NOTE_E) e_run++;
            else if (phase == 0) begin phase = 1; g_run = 1; end
            else if (phase == 1 && note === NOTE_NONE) g_run++;
            else phase = 2;
        end
        checks++;
        if (e_run != 70 || g_run != 10) begin
            errors++;
            $display("FAIL slow_tick_len got %0d/%0d exp 70/10", e_run, g_run);
        end
        stop = 1'b1; tick = 1'b0;
        @(negedge CLK);
        stop = 1'b0;
    endtask

    task automatic test_loop();
        bit saw_done = 0;
        bit dropped = 0;
        tick = 1'b1; loop = 1'b1;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        for (int j = 1; j <= 140; j++) begin
            @(negedge CLK);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL loop j=%0d got %h exp %h", j, obs(), expv());
            end
            if (done === 1'b1) saw_done = 1;
            if (busy !== 1'b1) dropped = 1;
            if (j == 128) begin
                checks++;
                if (note !== NOTE_E) begin
                    errors++;
                    $display("FAIL loop_wrap got %h exp %h", note, NOTE_E);
                end
            end
        end
        checks++;
        if (saw_done || dropped) begin
            errors++;
            $display("FAIL loop_busy got done=%b drop=%b exp 0 0", saw_done, dropped);
        end
        loop = 1'b0; stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
    endtask

    task automatic test_stop();
        tick = 1'b1; loop = 1'b0;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (58) @(negedge CLK);
        checks++;
        if (note !== NOTE_D) begin
            errors++;
            $display("FAIL stop_idx7 got %h exp %h", note, NOTE_D);
        end
        stop = 1'b1; start = 1'b1;
        @(negedge CLK);
        stop = 1'b0; start = 1'b0;
        checks++;
        if (obs() !== 14'h0) begin
            errors++;
            $display("FAIL stop_abort got %h exp %h", obs(), 14'h0);
        end
        repeat (3) @(negedge CLK);
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        checks++;
        if (note !== NOTE_E || busy !== 1'b1) begin
            errors++;
            $display("FAIL stop_restart got %h/%b exp %h/1", note, busy, NOTE_E);
        end
        repeat (127) @(negedge CLK);
        stop = 1'b1;
        @(negedge CLK);
        stop = 1'b0;
        checks++;
        if (obs() !== 14'h0) begin
            errors++;
            $display("FAIL stop_terminal got %h exp %h", obs(), 14'h0);
        end
    endtask

    task automatic test_random();
        for (int j = 0; j < 3000; j++) begin
            tick  = ($urandom_range(0, 2) == 0);
            start = ($urandom_range(0, 15) == 0);
            stop  = ($urandom_range(0, 299) == 0);
            loop  = $urandom_range(0, 1) == 1;
            @(negedge CLK);
            checks++;
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL random j=%0d got %h exp %h", j, obs(), expv());
            end
        end
        tick = 0; start = 0; stop = 0; loop = 0;
    endtask

    initial begin
        test_reset();
        test_play_once(1'b0, "play");
        test_slow_tick();
        test_loop();
        test_stop();
        test_play_once(1'b1, "start_busy");
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
